// File: rtl/gpu_tex_pkg.sv
// Shared texture-path types: pixel formats, texel address width and the
// sampled texture register set, plus the per-format column/sub-texel helpers.
package gpu_tex_pkg;

  localparam int TEXEL_ADDR_W = 19;

  typedef enum logic [1:0] {
    PIX_4BIT     = 2'd0,
    PIX_8BIT     = 2'd1,
    PIX_16BIT    = 2'd2,
    PIX_RESERVED = 2'd3
  } tex_fmt_e;

  typedef struct packed {
    logic [3:0] page_x;
    logic       page_y;
    logic       x_flip;
    logic       y_flip;
    tex_fmt_e   fmt;
    logic [4:0] mask_x;
    logic [4:0] mask_y;
    logic [4:0] off_x;
    logic [4:0] off_y;
  } tex_regs_t;

  // Half-word column within VRAM; packed formats squeeze several texels per column.
  function automatic logic [9:0] texel_x(input logic [3:0] page_x, input tex_fmt_e fmt,
                                         input logic [7:0] u);
    logic [9:0] col;
    case (fmt)
      PIX_4BIT: col = {4'b0, u[7:2]};
      PIX_8BIT: col = {3'b0, u[7:1]};
      default:  col = {2'b0, u};
    endcase
    return {page_x, 6'b0} + col;
  endfunction

  function automatic logic [1:0] texel_sub(input tex_fmt_e fmt, input logic [1:0] u_lo);
    case (fmt)
      PIX_4BIT: return u_lo;
      PIX_8BIT: return {1'b0, u_lo[0]};
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/tex_window_map.sv
// Per-channel coordinate flip followed by texture-window masking (8-texel steps).
module tex_window_map (
  input  logic [7:0] u_i,
  input  logic [7:0] v_i,
  input  logic       x_flip_i,
  input  logic       y_flip_i,
  input  logic [4:0] mask_x_i,
  input  logic [4:0] mask_y_i,
  input  logic [4:0] off_x_i,
  input  logic [4:0] off_y_i,
  output logic [7:0] u_o,
  output logic [7:0] v_o
);

  logic [7:0] u_f;
  logic [7:0] v_f;

  assign u_f = x_flip_i ? ~u_i : u_i;
  assign v_f = y_flip_i ? ~v_i : v_i;

  assign u_o = (u_f & ~{mask_x_i, 3'b000}) | {off_x_i & mask_x_i, 3'b000};
  assign v_o = (v_f & ~{mask_y_i, 3'b000}) | {off_y_i & mask_y_i, 3'b000};

endmodule

// File: rtl/tex_addr_pipe.sv
// Two-stage texel address generator: S1 holds windowed coordinates, S2 holds
// VRAM half-word addresses, sub-texel selectors and duplicate-address flags.
module tex_addr_pipe
  import gpu_tex_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int TAG_W  = 4
) (
  input  logic                           clk,
  input  logic                           i_nRst,
  input  logic [3:0]                     GPU_REG_TexBasePageX,
  input  logic                           GPU_REG_TexBasePageY,
  input  logic                           GPU_REG_TextureXFlip,
  input  logic                           GPU_REG_TextureYFlip,
  input  logic [1:0]                     GPU_REG_TexFormat,
  input  logic [4:0]                     GPU_REG_WindowTextureMaskX,
  input  logic [4:0]                     GPU_REG_WindowTextureMaskY,
  input  logic [4:0]                     GPU_REG_WindowTextureOffsetX,
  input  logic [4:0]                     GPU_REG_WindowTextureOffsetY,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [NUM_CH*8-1:0]            i_coordU,
  input  logic [NUM_CH*8-1:0]            i_coordV,
  input  logic [TAG_W-1:0]               i_tag,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [NUM_CH*TEXEL_ADDR_W-1:0] o_texelAdress,
  output logic [NUM_CH*2-1:0]            o_subSel,
  output logic [NUM_CH-1:0]              o_dup,
  output logic [TAG_W-1:0]               o_tag
);

  tex_regs_t regs;
  assign regs = '{
    page_x: GPU_REG_TexBasePageX,  page_y: GPU_REG_TexBasePageY,
    x_flip: GPU_REG_TextureXFlip,  y_flip: GPU_REG_TextureYFlip,
    fmt:    tex_fmt_e'(GPU_REG_TexFormat),
    mask_x: GPU_REG_WindowTextureMaskX,   mask_y: GPU_REG_WindowTextureMaskY,
    off_x:  GPU_REG_WindowTextureOffsetX, off_y:  GPU_REG_WindowTextureOffsetY
  };

  logic s1_valid_q, s2_valid_q;
  logic s2_load, accept;

  // o_ready depends only on pipeline state and i_ready, never on i_valid.
  assign s2_load = ~s2_valid_q | i_ready;
  assign o_ready = ~s1_valid_q | s2_load;
  assign accept  = i_valid & o_ready;

  // ---------------- Stage 1 ----------------
  logic [7:0] win_u [NUM_CH];
  logic [7:0] win_v [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_win
    tex_window_map u_map (
      .u_i      (i_coordU[8*k +: 8]),
      .v_i      (i_coordV[8*k +: 8]),
      .x_flip_i (regs.x_flip),
      .y_flip_i (regs.y_flip),
      .mask_x_i (regs.mask_x),
      .mask_y_i (regs.mask_y),
      .off_x_i  (regs.off_x),
      .off_y_i  (regs.off_y),
      .u_o      (win_u[k]),
      .v_o      (win_v[k])
    );
  end

  logic [7:0]       s1_u_q [NUM_CH];
  logic [7:0]       s1_v_q [NUM_CH];
  logic [3:0]       s1_page_x_q;
  logic             s1_page_y_q;
  tex_fmt_e         s1_fmt_q;
  logic [TAG_W-1:0] s1_tag_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      s1_valid_q  <= 1'b0;
      s1_page_x_q <= '0;
      s1_page_y_q <= 1'b0;
      s1_fmt_q    <= PIX_4BIT;
      s1_tag_q    <= '0;
      // NOTE: these per-channel arrays are plain flops, so resetting them is cheap;
      // a real RAM would be left unreset and qualified by the valid bit instead.
      for (int k = 0; k < NUM_CH; k++) begin
        s1_u_q[k] <= '0;
        s1_v_q[k] <= '0;
      end
    end else begin
      if (o_ready) s1_valid_q <= i_valid;
      if (accept) begin
        s1_page_x_q <= regs.page_x;
        s1_page_y_q <= regs.page_y;
        s1_fmt_q    <= regs.fmt;
        s1_tag_q    <= i_tag;
        for (int k = 0; k < NUM_CH; k++) begin
          s1_u_q[k] <= win_u[k];
          s1_v_q[k] <= win_v[k];
        end
      end
    end
  end

  // ---------------- Stage 2 ----------------
  logic [NUM_CH*TEXEL_ADDR_W-1:0] addr_d;
  logic [NUM_CH*2-1:0]            sub_d;
  logic [NUM_CH-1:0]              dup_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    addr_d = '0;
    sub_d  = '0;
    dup_d  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      addr_d[k*TEXEL_ADDR_W +: TEXEL_ADDR_W] =
        {s1_page_y_q, s1_v_q[k], texel_x(s1_page_x_q, s1_fmt_q, s1_u_q[k])};
      sub_d[2*k +: 2] = texel_sub(s1_fmt_q, s1_u_q[k][1:0]);
    end
    // Duplicate detection looks at addresses only; a repeated half-word is fetched once.
    for (int k = 1; k < NUM_CH; k++) begin
      for (int j = 0; j < k; j++) begin
        if (addr_d[j*TEXEL_ADDR_W +: TEXEL_ADDR_W] == addr_d[k*TEXEL_ADDR_W +: TEXEL_ADDR_W])
          dup_d[k] = 1'b1;
      end
    end
  end

  logic [NUM_CH*TEXEL_ADDR_W-1:0] s2_addr_q;
  logic [NUM_CH*2-1:0]            s2_sub_q;
  logic [NUM_CH-1:0]              s2_dup_q;
  logic [TAG_W-1:0]               s2_tag_q;

  always_ff @(posedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_sub_q   <= '0;
      s2_dup_q   <= '0;
      s2_tag_q   <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q <= addr_d;
        s2_sub_q  <= sub_d;
        s2_dup_q  <= dup_d;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign o_valid       = s2_valid_q;
  assign o_texelAdress = s2_addr_q;
  assign o_subSel      = s2_sub_q;
  assign o_dup         = s2_dup_q;
  assign o_tag         = s2_tag_q;

endmodule

// File: tb/tb_tex_addr_pipe.sv
// Randomized and directed bench for tex_addr_pipe against an arithmetic texel model.
module tb_tex_addr_pipe;

  localparam int NUM_CH = 2;
  localparam int TAG_W  = 4;
  localparam int AW     = 19;

  logic clk, i_nRst;
  logic [3:0] GPU_REG_TexBasePageX;
  logic GPU_REG_TexBasePageY, GPU_REG_TextureXFlip, GPU_REG_TextureYFlip;
  logic [1:0] GPU_REG_TexFormat;
  logic [4:0] GPU_REG_WindowTextureMaskX, GPU_REG_WindowTextureMaskY;
  logic [4:0] GPU_REG_WindowTextureOffsetX, GPU_REG_WindowTextureOffsetY;
  logic i_valid, o_ready, o_valid, i_ready;
  logic [NUM_CH*8-1:0] i_coordU, i_coordV;
  logic [TAG_W-1:0] i_tag, o_tag;
  logic [NUM_CH*AW-1:0] o_texelAdress;
  logic [NUM_CH*2-1:0] o_subSel;
  logic [NUM_CH-1:0] o_dup;

  tex_addr_pipe #(.NUM_CH(NUM_CH), .TAG_W(TAG_W)) dut (
    .clk(clk), .i_nRst(i_nRst),
    .GPU_REG_TexBasePageX(GPU_REG_TexBasePageX), .GPU_REG_TexBasePageY(GPU_REG_TexBasePageY),
    .GPU_REG_TextureXFlip(GPU_REG_TextureXFlip), .GPU_REG_TextureYFlip(GPU_REG_TextureYFlip),
    .GPU_REG_TexFormat(GPU_REG_TexFormat),
    .GPU_REG_WindowTextureMaskX(GPU_REG_WindowTextureMaskX),
    .GPU_REG_WindowTextureMaskY(GPU_REG_WindowTextureMaskY),
    .GPU_REG_WindowTextureOffsetX(GPU_REG_WindowTextureOffsetX),
    .GPU_REG_WindowTextureOffsetY(GPU_REG_WindowTextureOffsetY),
    .i_valid(i_valid), .o_ready(o_ready), .i_coordU(i_coordU), .i_coordV(i_coordV),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_texelAdress(o_texelAdress),
    .o_subSel(o_subSel), .o_dup(o_dup), .o_tag(o_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH*AW-1:0] addr;
    logic [NUM_CH*2-1:0]  sub;
    logic [NUM_CH-1:0]    dup;
    logic [TAG_W-1:0]     tag;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  logic hold_valid;
  int total, bad, n_in, n_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window works on the 8-texel block index: masked block bits come from the offset.
  function automatic int window(input int c, input int m, input int o);
    int blk, r;
    blk = c / 8;
    r = 0;
    for (int b = 0; b < 5; b++)
      r += ((((m >> b) & 1) != 0) ? ((o >> b) & 1) : ((blk >> b) & 1)) << b;
    return (c % 8) + 8 * r;
  endfunction

  function automatic exp_t model(input logic [NUM_CH*8-1:0] cu, input logic [NUM_CH*8-1:0] cv,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    int u, v, tph, x;
    int a [NUM_CH];
    e = '0;
    tph = (GPU_REG_TexFormat == 2'd0) ? 4 : (GPU_REG_TexFormat == 2'd1) ? 2 : 1;
    for (int k = 0; k < NUM_CH; k++) begin
      u = int'(cu[8*k +: 8]);
      v = int'(cv[8*k +: 8]);
      if (GPU_REG_TextureXFlip) u = 255 - u;
      if (GPU_REG_TextureYFlip) v = 255 - v;
      u = window(u, int'(GPU_REG_WindowTextureMaskX), int'(GPU_REG_WindowTextureOffsetX));
      v = window(v, int'(GPU_REG_WindowTextureMaskY), int'(GPU_REG_WindowTextureOffsetY));
      x = (int'(GPU_REG_TexBasePageX) * 64 + u / tph) % 1024;
      a[k] = int'(GPU_REG_TexBasePageY) * 262144 + v * 1024 + x;
      e.addr[AW*k +: AW] = a[k][AW-1:0];
      e.sub[2*k +: 2] = 2'(u % tph);
      for (int j = 0; j < k; j++)
        if (a[j] == a[k]) e.dup[k] = 1'b1;
    end
    e.tag = tag;
    return e;
  endfunction

  // One clock: sample settled outputs, score emits/stalls, record accepts, advance.
  task automatic cycle_step();
    exp_t e;
    #1;
    if (hold_valid) begin
      check("stall_valid", 64'(o_valid), 64'(1));
      check("stall_addr", 64'(o_texelAdress), 64'(held.addr));
      check("stall_sub", 64'(o_subSel), 64'(held.sub));
      check("stall_dup", 64'(o_dup), 64'(held.dup));
      check("stall_tag", 64'(o_tag), 64'(held.tag));
    end
    hold_valid = 1'b0;
    if (o_valid) begin
      if (i_ready) begin
        check("out_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_addr", 64'(o_texelAdress), 64'(e.addr));
          check("out_sub", 64'(o_subSel), 64'(e.sub));
          check("out_dup", 64'(o_dup), 64'(e.dup));
          check("out_tag", 64'(o_tag), 64'(e.tag));
        end
        n_out++;
      end else begin
        held = '{addr: o_texelAdress, sub: o_subSel, dup: o_dup, tag: o_tag};
        hold_valid = 1'b1;
      end
    end
    if (i_valid && o_ready) begin
      sb.push_back(model(i_coordU, i_coordV, i_tag));
      n_in++;
    end
    @(negedge clk);
  endtask

  task automatic set_regs(input logic [3:0] px, input logic [1:0] fmt, input logic xf,
                          input logic [4:0] mx, input logic [4:0] ox);
    GPU_REG_TexBasePageX = px;
    GPU_REG_TexBasePageY = 1'b0;
    GPU_REG_TextureXFlip = xf;
    GPU_REG_TextureYFlip = 1'b0;
    GPU_REG_TexFormat = fmt;
    GPU_REG_WindowTextureMaskX = mx;
    GPU_REG_WindowTextureOffsetX = ox;
    GPU_REG_WindowTextureMaskY = 5'd0;
    GPU_REG_WindowTextureOffsetY = 5'd0;
  endtask

  // Present one request, optionally retarget the format right after acceptance,
  // and wait (bounded) for the result to appear.
  task automatic run_one(input string tag, input logic [1:0] fmt_after);
    int lat;
    i_valid = 1'b1;
    i_ready = 1'b1;
    check({tag, "_accept"}, 64'(o_ready), 64'(1));
    cycle_step();
    i_valid = 1'b0;
    GPU_REG_TexFormat = fmt_after;
    lat = 1;
    while (!o_valid && lat < 8) begin
      cycle_step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(2));
  endtask

  initial begin
    int seen;
    total = 0; bad = 0; n_in = 0; n_out = 0; hold_valid = 1'b0;
    i_nRst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_coordU = '0; i_coordV = '0; i_tag = '0;
    set_regs(4'd0, 2'd2, 1'b0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    i_nRst = 1'b1;
    #1;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_ready", 64'(o_ready), 64'(1));
    check("rst_addr", 64'(o_texelAdress), 64'(0));
    check("rst_sub", 64'(o_subSel), 64'(0));
    check("rst_dup", 64'(o_dup), 64'(0));
    check("rst_tag", 64'(o_tag), 64'(0));
    @(negedge clk);

    // Basic 16-bit request: both lanes land on {0,0x05,0x050}.
    set_regs(4'd1, 2'd2, 1'b0, 5'd0, 5'd0);
    i_coordU = 16'h1010; i_coordV = 16'h0505; i_tag = 4'd3;
    run_one("basic", 2'd2);
    check("basic_addr", 64'(o_texelAdress), 64'({19'h01450, 19'h01450}));
    check("basic_dup", 64'(o_dup), 64'(2'b10));
    check("basic_tag", 64'(o_tag), 64'(3));
    cycle_step();

    // 4-bit at the top page: x = 1023, subSel = 3.
    set_regs(4'd15, 2'd0, 1'b0, 5'd0, 5'd0);
    i_coordU = 16'h00FF; i_coordV = 16'h0000; i_tag = 4'd4;
    run_one("fmt4", 2'd0);
    check("fmt4_addr0", 64'(o_texelAdress[AW-1:0]), 64'(1023));
    check("fmt4_sub0", 64'(o_subSel[1:0]), 64'(3));
    check("fmt4_dup", 64'(o_dup), 64'(0));
    cycle_step();

    // 16-bit at the top page wraps: (960 + 255) mod 1024 = 191.
    set_regs(4'd15, 2'd2, 1'b0, 5'd0, 5'd0);
    run_one("wrap", 2'd2);
    check("wrap_addr0", 64'(o_texelAdress[AW-1:0]), 64'(191));
    check("wrap_sub0", 64'(o_subSel[1:0]), 64'(0));
    cycle_step();

    // Window plus flip: U=0 flips to 0xFF, window forces result 0x57.
    set_regs(4'd0, 2'd2, 1'b1, 5'h1F, 5'h0A);
    i_coordU = 16'h0000; i_tag = 4'd5;
    run_one("window", 2'd2);
    check("window_addr", 64'(o_texelAdress), 64'({19'h00057, 19'h00057}));
    check("window_dup", 64'(o_dup), 64'(2'b10));
    cycle_step();

    // Format changes right after acceptance; the request keeps 16-bit.
    set_regs(4'd0, 2'd2, 1'b0, 5'd0, 5'd0);
    i_coordU = 16'h8040; i_tag = 4'd6;
    run_one("fmtchg", 2'd0);
    check("fmtchg_addr", 64'(o_texelAdress), 64'({19'h00080, 19'h00040}));
    cycle_step();

    // Random stream of 16 with random back-pressure and random register sets.
    begin
      int in0, out0;
      in0 = n_in;
      out0 = n_out;
      for (int c = 0; c < 600 && (n_in - in0 < 16 || sb.size() != 0); c++) begin
        i_valid = (n_in - in0 < 16) && ($urandom_range(0, 3) != 0);
        i_ready = 1'($urandom_range(0, 1));
        i_tag = 4'(n_in - in0);
        i_coordU = NUM_CH*8'($urandom);
        i_coordV = NUM_CH*8'($urandom);
        for (int k = 1; k < NUM_CH; k++)
          if ($urandom_range(0, 1) == 1) begin
            i_coordU[8*k +: 8] = i_coordU[7:0];
            i_coordV[8*k +: 8] = i_coordV[7:0];
          end
        GPU_REG_TexBasePageX = 4'($urandom);
        GPU_REG_TexBasePageY = 1'($urandom);
        GPU_REG_TextureXFlip = 1'($urandom);
        GPU_REG_TextureYFlip = 1'($urandom);
        GPU_REG_TexFormat = 2'($urandom);
        GPU_REG_WindowTextureMaskX = 5'($urandom);
        GPU_REG_WindowTextureMaskY = 5'($urandom);
        GPU_REG_WindowTextureOffsetX = 5'($urandom);
        GPU_REG_WindowTextureOffsetY = 5'($urandom);
        cycle_step();
      end
      check("stream_in", 64'(n_in - in0), 64'(16));
      check("stream_out", 64'(n_out - out0), 64'(16));
      check("stream_left", 64'(sb.size()), 64'(0));
    end

    // Fill both stages under stall, then reset mid-flight.
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (2) cycle_step();
    set_regs(4'd2, 2'd1, 1'b0, 5'd0, 5'd0);
    i_valid = 1'b1; i_ready = 1'b0;
    cycle_step();
    cycle_step();
    i_valid = 1'b0;
    #1;
    check("full_valid", 64'(o_valid), 64'(1));
    check("full_ready", 64'(o_ready), 64'(0));
    #2;
    i_nRst = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'(0));
    check("midrst_ready", 64'(o_ready), 64'(1));
    sb.delete();
    hold_valid = 1'b0;
    @(negedge clk);
    i_nRst = 1'b1;
    i_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check("midrst_no_emit", 64'(seen), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
